commit_regfile_rat: RTL and testbench
=====================================

// Module: commit_regfile_rat
// PURPOSE
//  Architectural register file plus register alias table (busy bit + ROB tag per register).
//  Sits directly downstream of the reorder buffer: it consumes in-order commits (dest, value, tag).
//  Decode/issue also uses it: dispatch marks rd busy with its ROB tag, and operand reads return
//  committed data or busy+tag. Flush clears all speculative mappings; committed state is kept.
// PARAMETERS
//  XLEN   32  data width
//  NREG   32  architectural registers; x0 is hard-wired to zero
//  TAG_W  6   ROB tag width (64-entry ROB)
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      asynchronous, active-low reset (0 = reset)
//  flush          in   1      ROB flush; clears all busy bits
//  disp_valid     in   1      instruction dispatched this cycle
//  disp_reg_write in   1      dispatched instruction writes rd
//  disp_rd        in   5      destination register of dispatched instruction
//  disp_tag       in   TAG_W  ROB slot allocated to dispatched instruction
//  commit_valid   in   1      single-cycle pulse: ROB head retires this cycle
//  commit_we      in   1      retiring instruction writes a register
//  commit_dest    in   5      retiring destination register
//  commit_value   in   XLEN   retiring result
//  commit_tag     in   TAG_W  ROB slot of retiring instruction
//  rs1_addr       in   5      read port 1 address
//  rs1_data       out  XLEN   read port 1 data (committed or bypassed)
//  rs1_busy       out  1      rs1 awaits an in-flight producer
//  rs1_tag        out  TAG_W  producer ROB tag when rs1_busy=1, else 0
//  rs2_addr/rs2_data/rs2_busy/rs2_tag  same as port 1
//  retired_cnt    out  32     number of commit_valid pulses since reset, wraps at 2^32
// BEHAVIOUR
//  Reset (rst=0, async): all registers=0, busy=0, tags=0, retired_cnt=0. Read outputs are then 0/0/0.
//  Commit write (posedge): when commit_valid & commit_we & commit_dest!=0, set reg[commit_dest]=commit_value.
//  Commit clear: when commit_valid & commit_we & busy[dest] & tag[dest]==commit_tag, clear busy[dest].
//   Tag mismatch: a younger producer owns the register, so busy/tag stay unchanged.
//  Dispatch (posedge): when disp_valid & disp_reg_write & disp_rd!=0 & !flush,
//   set busy[rd]=1 and tag[rd]=disp_tag.
//  Same-cycle dispatch and commit to the same rd: the dispatch wins (busy=1, tag=disp_tag),
//   and the register-file write still occurs.
//  flush=1: all busy bits and tags clear next edge; dispatch that cycle is ignored;
//   commit that cycle still writes the register file and increments retired_cnt.
//  Reads are combinational, with zero latency:
//   addr==0                  -> data=0, busy=0, tag=0
//   commit writing addr now  -> data=commit_value (bypass); busy=0 if this commit clears it
//   otherwise                -> data=reg[addr], busy=busy[addr], tag=busy?tag[addr]:0
//   Reads never see a same-cycle dispatch; the decoder handles rd==rs intra-bundle hazards.
//  retired_cnt increments by 1 on every commit_valid, including commit_we=0 (stores, branches).
//  commit_valid must be a pulse per retirement. A held level re-writes the same value (harmless)
//   but counts each cycle; the upstream stage guarantees pulses.
//  Reset asserted mid-operation: all state is discarded immediately, with no partial commit.
// STRUCTURE
//  Shared package cpu_pkg: XLEN, NREG, TAG_W, typedef reg_idx_t [4:0], typedef rob_tag_t [TAG_W-1:0].
//  Sub-module rat_table holds busy[NREG] and tag[NREG] with the set/clear/flush rules above,
//   plus the two tag/busy lookups.
//  Top level holds the 32xXLEN storage array, bypass muxes and retired_cnt.
// TESTING
//  1 Reset: rst=0 then 1; read all 32 addrs -> data=0, busy=0, tag=0; retired_cnt=0.
//  2 Dispatch rd=5 tag=3; next cycle rs1=5 -> busy=1 tag=3. Commit dest=5 tag=3 val=0xDEADBEEF
//     -> same cycle rs1_data=0xDEADBEEF busy=0; next cycle same from storage.
//  3 Dispatch rd=7 tag=1, then rd=7 tag=2; commit tag=1 val=0x11 -> reg7=0x11 but busy=1 tag=2;
//     commit tag=2 val=0x22 -> busy=0, data=0x22.
//  4 Same cycle: commit dest=9 tag=4 (busy,tag=4) and dispatch rd=9 tag=8 -> busy=1 tag=8,
//     reg9=commit value.
//  5 Busy on regs 1..4, flush=1 with dispatch rd=6 and commit dest=2 val=0x55 -> all busy=0,
//     reg2=0x55, reg6 not busy, retired_cnt+1.
//  6 x0: dispatch rd=0, commit dest=0 val=0xFFFF -> rs1=0 reads data=0, busy=0; retired_cnt+1.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared widths and index/tag types for the commit/RAT slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int TAG_W = 6;

    typedef logic [4:0]       reg_idx_t;
    typedef logic [TAG_W-1:0] rob_tag_t;
endpackage

`default_nettype wire

// File: rtl/rat_table.sv
// ============================================================================
// Module  : rat_table
// Brief   : Register alias table: busy bit and producer ROB tag per register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rat_table
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     disp_valid,
    input  logic     disp_reg_write,
    input  reg_idx_t disp_rd,
    input  rob_tag_t disp_tag,
    input  logic     commit_valid,
    input  logic     commit_we,
    input  reg_idx_t commit_dest,
    input  rob_tag_t commit_tag,
    input  reg_idx_t rs1_addr,
    output logic     rs1_busy,
    output rob_tag_t rs1_tag,
    input  reg_idx_t rs2_addr,
    output logic     rs2_busy,
    output rob_tag_t rs2_tag
);

    logic     r_busy [NREG];
    rob_tag_t r_tag  [NREG];

    logic w_commit_wr;
    logic w_disp_wr;

    assign w_commit_wr = commit_valid & commit_we;
    assign w_disp_wr   = disp_valid & disp_reg_write & ~flush;

    generate
        for (genvar i = 0; i < NREG; i++) begin : g_entry
            localparam bit c_WRITABLE = (i != 0);
            logic w_set;
            logic w_clr;

            assign w_set = c_WRITABLE & w_disp_wr & (disp_rd == reg_idx_t'(i));
            assign w_clr = w_commit_wr & (commit_dest == reg_idx_t'(i))
                         & (r_tag[i] == commit_tag);

            // Priority flush > dispatch > commit clear: a younger dispatch keeps ownership.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_busy[i] <= 1'b0;
                    r_tag[i]  <= '0;
                end else if (flush) begin
                    r_busy[i] <= 1'b0;
                    r_tag[i]  <= '0;
                end else if (w_set) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= disp_tag;
                end else if (w_clr) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    endgenerate

    // A commit retiring the current producer makes the operand ready this cycle.
    function automatic logic lookup_busy(input reg_idx_t a);
        return (a != '0) && r_busy[a]
               && !(w_commit_wr && (commit_dest == a) && (r_tag[a] == commit_tag));
    endfunction

    assign rs1_busy = lookup_busy(rs1_addr);
    assign rs1_tag  = rs1_busy ? r_tag[rs1_addr] : '0;
    assign rs2_busy = lookup_busy(rs2_addr);
    assign rs2_tag  = rs2_busy ? r_tag[rs2_addr] : '0;

endmodule

`default_nettype wire

// File: rtl/commit_regfile_rat.sv
// ============================================================================
// Module  : commit_regfile_rat
// Brief   : Architectural register file with commit bypass, RAT and retire count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_regfile_rat
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            disp_valid,
    input  logic            disp_reg_write,
    input  reg_idx_t        disp_rd,
    input  rob_tag_t        disp_tag,
    input  logic            commit_valid,
    input  logic            commit_we,
    input  reg_idx_t        commit_dest,
    input  logic [XLEN-1:0] commit_value,
    input  rob_tag_t        commit_tag,
    input  reg_idx_t        rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic            rs1_busy,
    output rob_tag_t        rs1_tag,
    input  reg_idx_t        rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs2_busy,
    output rob_tag_t        rs2_tag,
    output logic [31:0]     retired_cnt
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [31:0]     r_retired_cnt;
    logic            w_rf_wr;

    assign w_rf_wr = commit_valid & commit_we & (commit_dest != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_retired_cnt <= '0;
        end else begin
            if (w_rf_wr) begin
                r_regs[commit_dest] <= commit_value;
            end
            if (commit_valid) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
        end
    end

    function automatic logic [XLEN-1:0] read_data(input reg_idx_t a);
        if (a == '0)                          return '0;
        else if (w_rf_wr && commit_dest == a) return commit_value;
        else                                  return r_regs[a];
    endfunction

    assign rs1_data    = read_data(rs1_addr);
    assign rs2_data    = read_data(rs2_addr);
    assign retired_cnt = r_retired_cnt;

    rat_table u_rat (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_reg_write (disp_reg_write),
        .disp_rd        (disp_rd),
        .disp_tag       (disp_tag),
        .commit_valid   (commit_valid),
        .commit_we      (commit_we),
        .commit_dest    (commit_dest),
        .commit_tag     (commit_tag),
        .rs1_addr       (rs1_addr),
        .rs1_busy       (rs1_busy),
        .rs1_tag        (rs1_tag),
        .rs2_addr       (rs2_addr),
        .rs2_busy       (rs2_busy),
        .rs2_tag        (rs2_tag)
    );

endmodule

`default_nettype wire

// File: tb/tb_commit_regfile_rat.sv
// ============================================================================
// Module  : tb_commit_regfile_rat
// Brief   : Scoreboard bench for commit_regfile_rat against an array-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_regfile_rat;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        disp_valid = 1'b0, disp_reg_write = 1'b0;
    logic [4:0]  disp_rd = '0;
    logic [5:0]  disp_tag = '0;
    logic        commit_valid = 1'b0, commit_we = 1'b0;
    logic [4:0]  commit_dest = '0;
    logic [31:0] commit_value = '0;
    logic [5:0]  commit_tag = '0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0;
    logic [31:0] rs1_data, rs2_data, retired_cnt;
    logic        rs1_busy, rs2_busy;
    logic [5:0]  rs1_tag, rs2_tag;

    commit_regfile_rat dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_reg_write(disp_reg_write),
        .disp_rd(disp_rd), .disp_tag(disp_tag),
        .commit_valid(commit_valid), .commit_we(commit_we),
        .commit_dest(commit_dest), .commit_value(commit_value), .commit_tag(commit_tag),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d1; logic b1; logic [5:0] t1;
        logic [31:0] d2; logic b2; logic [5:0] t2;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Architectural reference state
    logic [31:0] m_reg  [32];
    bit          m_busy [32];
    logic [5:0]  m_tag  [32];
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
        end
        m_cnt = '0;
    endtask

    task automatic model_read(input logic [4:0] a, input logic cv, cw, input logic [4:0] cd,
                              input logic [31:0] cval, input logic [5:0] ctag,
                              output logic [31:0] d, output logic b, output logic [5:0] t);
        d = '0; b = 1'b0; t = '0;
        if (a != 0) begin
            d = (cv && cw && cd == a) ? cval : m_reg[a];
            b = m_busy[a] && !(cv && cw && cd == a && m_tag[a] == ctag);
            t = b ? m_tag[a] : 6'd0;
        end
    endtask

    // One clock of stimulus: drive, queue the expected read response, advance the model.
    task automatic step(input logic r, fl, dv, dw, input logic [4:0] drd, input logic [5:0] dtg,
                        input logic cv, cw, input logic [4:0] cd, input logic [31:0] cval,
                        input logic [5:0] ctg, input logic [4:0] a1, a2);
        exp_t e;
        @(posedge clk); #1;
        rst = r; flush = fl; disp_valid = dv; disp_reg_write = dw; disp_rd = drd; disp_tag = dtg;
        commit_valid = cv; commit_we = cw; commit_dest = cd; commit_value = cval; commit_tag = ctg;
        rs1_addr = a1; rs2_addr = a2;
        if (!r) begin
            model_reset();
            e = '{d1:0, b1:0, t1:0, d2:0, b2:0, t2:0, cnt:0};
        end else begin
            model_read(a1, cv, cw, cd, cval, ctg, e.d1, e.b1, e.t1);
            model_read(a2, cv, cw, cd, cval, ctg, e.d2, e.b2, e.t2);
            e.cnt = m_cnt;
            if (cv && cw && cd != 0) m_reg[cd] = cval;
            if (cv && cw && m_busy[cd] && m_tag[cd] == ctg) m_busy[cd] = 0;
            if (fl) begin
                for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = '0; end
            end else if (dv && dw && drd != 0) begin
                m_busy[drd] = 1; m_tag[drd] = dtg;
            end
            if (cv) m_cnt = m_cnt + 1;
        end
        q.push_back(e);
    endtask

    task automatic idle(input logic [4:0] a1, a2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a1, a2);
    endtask

    // Monitor: outputs are combinational, so they are sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rs1_data", rs1_data, e.d1);
                chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, e.b1});
                chk("rs1_tag", {26'd0, rs1_tag}, {26'd0, e.t1});
                chk("rs2_data", rs2_data, e.d2);
                chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, e.b2});
                chk("rs2_tag", {26'd0, rs2_tag}, {26'd0, e.t2});
                chk("retired_cnt", retired_cnt, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, queue=%0d", q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] cd, drd;
        logic [5:0] ctg;
        bit         rr, fl, cv;
        model_reset();

        // Reset held: every address reads zero
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(i + 16));
        for (int i = 0; i < 16; i++) idle(5'(i), 5'(i + 16));

        // Dispatch then commit with same-cycle bypass
        step(1, 0, 1, 1, 5, 3, 0, 0, 0, 0, 0, 0, 0);
        idle(5, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1, 5, 32'hDEADBEEF, 3, 5, 5);
        idle(5, 5);

        // Older commit must not release a register owned by a younger producer
        step(1, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 7, 0);
        step(1, 0, 1, 1, 7, 2, 0, 0, 0, 0, 0, 7, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1, 7, 32'h11, 1, 7, 7);
        idle(7, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1, 7, 32'h22, 2, 7, 7);
        idle(7, 7);

        // Same-cycle commit and dispatch to one register
        step(1, 0, 1, 1, 9, 4, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 9, 8, 1, 1, 9, 32'hCAFE0009, 4, 9, 9);
        idle(9, 9);

        // Flush with concurrent dispatch and commit
        for (int i = 1; i <= 4; i++) step(1, 0, 1, 1, 5'(i), 6'(10 + i), 0, 0, 0, 0, 0, 5'(i), 0);
        step(1, 1, 1, 1, 6, 20, 1, 1, 2, 32'h55, 40, 2, 6);
        for (int i = 1; i <= 6; i++) idle(5'(i), 5'(7 - i));

        // x0 stays zero and never busy; retirement still counts
        step(1, 0, 1, 1, 0, 9, 1, 1, 0, 32'hFFFF, 9, 0, 0);
        idle(0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 3, 32'h1234, 0, 3, 0);
        idle(3, 0);

        // Mid-operation asynchronous reset
        step(1, 0, 1, 1, 12, 5, 1, 1, 12, 32'hAAAA, 0, 12, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 9);
        idle(12, 9);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            rr  = ($urandom_range(0, 299) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            cv  = rr && ($urandom_range(0, 1) == 1);
            drd = 5'($urandom_range(0, 31));
            cd  = 5'($urandom_range(0, 31));
            ctg = 6'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_busy[cd]) break;
                    cd = 5'($urandom_range(0, 31));
                end
                if (m_busy[cd] && $urandom_range(0, 3) != 0) ctg = m_tag[cd];
            end
            step(rr, fl, 1'($urandom), 1'($urandom_range(0, 3) != 0), drd, 6'($urandom),
                 cv, 1'($urandom_range(0, 3) != 0), cd, $urandom, ctg,
                 ($urandom_range(0, 1) == 1) ? cd : 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));
        end

        idle(0, 0);
        @(posedge clk); #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
